hamming_decode_pipe: RTL

HAMMING_DECODE_PIPE -- requirements
Module: hamming_decode_pipe

---
 rtl/gray_area_package.sv | 28 ++
 rtl/hamming_unpack.sv | 38 +++
 rtl/hamming_decode_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gray_area_package.sv
// -----------------------------------------------------------------------------
// gray_area_package
// Shared types and helpers for the Hamming SECDED blocks.
//   hamming_address_width(data_width) : number of Hamming check bits r, the
//                                       smallest r with 2**r >= data_width+r+1
//   hamming_status_e                  : decode result classification
// No ports (package).
// -----------------------------------------------------------------------------
package gray_area_package;

   function automatic int hamming_address_width(input int data_width);
      int r;
      r = 0;
      for (int i = 1; i < 31; i++) begin
         if ((r == 0) && ((1 << i) >= (data_width + i + 1))) begin
            r = i;
         end
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      HAM_OK            = 2'd0,
      HAM_CORRECTED     = 2'd1,
      HAM_UNCORRECTABLE = 2'd2
   } hamming_status_e;

endpackage

// File: rtl/hamming_unpack.sv
// -----------------------------------------------------------------------------
// hamming_unpack
// Extracts the payload from a SECDED codeword: every non-power-of-two
// position >= 3, in ascending order, lands in data_out starting at the LSB.
// Bit 0 (overall parity) and the power-of-two check bits are dropped.
// Ports:
//   code_in  [CODE_WIDTH-1:0]  codeword (CODE_WIDTH = DATA_WIDTH+ADDR_WIDTH+1)
//   data_out [DATA_WIDTH-1:0]  extracted payload
// -----------------------------------------------------------------------------
module hamming_unpack
   import gray_area_package::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH+hamming_address_width(DATA_WIDTH):0] code_in,
   output logic [DATA_WIDTH-1:0]                                 data_out
);

   localparam int ADDR_WIDTH = hamming_address_width(DATA_WIDTH);
   localparam int CODE_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

   // Check and parity bits are intentionally not part of the payload.
   logic unused_code_bits;
   assign unused_code_bits = ^code_in;

   always_comb begin
      int k;
      data_out = '0;
      k = 0;
      for (int pos = 3; pos < CODE_WIDTH; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            data_out[k] = code_in[pos];
            k++;
         end
      end
   end

endmodule

// File: rtl/hamming_decode_pipe.sv
// -----------------------------------------------------------------------------
// hamming_decode_pipe
// Two-stage SECDED decoder with valid/ready flow control.
//   S1: registers codeword, syndrome and overall parity.
//   S2: registers corrected payload and status.
// Handshake: a word moves across an interface on a clock edge where both
// valid and ready are 1; valid and its payload hold until accepted.
// Optional feature: define HAMMING_ERR_CNT_EN to build saturating counters of
// corrected / uncorrectable output words; otherwise the counter ports read 0
// and cnt_clr is ignored.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   code_in, in_valid   input codeword and its valid
//   in_ready            input accepted this cycle
//   data_out,status_out corrected payload and hamming_status_e
//   out_valid,out_ready output valid / downstream ready
//   cnt_clr             clear both counters (wins over increment)
//   corr_cnt,uncorr_cnt error counters
// -----------------------------------------------------------------------------
module hamming_decode_pipe
   import gray_area_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic [DATA_WIDTH+hamming_address_width(DATA_WIDTH):0] code_in,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   output logic [DATA_WIDTH-1:0]                                data_out,
   output hamming_status_e                                      status_out,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   input  logic                                                 cnt_clr,
   output logic [CNT_WIDTH-1:0]                                 corr_cnt,
   output logic [CNT_WIDTH-1:0]                                 uncorr_cnt
);

   localparam int ADDR_WIDTH = hamming_address_width(DATA_WIDTH);
   localparam int CODE_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic [ADDR_WIDTH-1:0] syn_q, syn_d;
   logic                  par_q, par_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   hamming_status_e       status_q, status_d;
   logic                  out_valid_q, out_valid_d;

   logic                  en1, en2;
   logic                  correctable;
   logic [CODE_WIDTH-1:0] flip_mask;
   logic [CODE_WIDTH-1:0] fixed_code;
   logic [DATA_WIDTH-1:0] unpacked;

   // S2 advances when empty or drained; S1 advances when empty or S2 moves.
   assign en2      = !out_valid_q || out_ready;
   assign en1      = !s1_valid_q || en2;
   assign in_ready = en1;

   // ---------------- Stage 1 ----------------
   always_comb begin
      code_d     = code_q;
      syn_d      = syn_q;
      par_d      = par_q;
      s1_valid_d = s1_valid_q;
      if (en1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            code_d = code_in;
            syn_d  = '0;
            for (int i = 1; i < CODE_WIDTH; i++) begin
               if (code_in[i]) syn_d = syn_d ^ ADDR_WIDTH'(i);
            end
            par_d = ^code_in;
         end
      end
   end

   // ---------------- Stage 2 ----------------
   // Odd parity with an in-range syndrome is a single-bit error at that
   // position; syndrome 0 points at the parity bit, which carries no data.
   always_comb begin
      correctable = par_q && ({1'b0, syn_q} < (ADDR_WIDTH + 1)'(CODE_WIDTH));
      flip_mask   = '0;
      for (int i = 0; i < CODE_WIDTH; i++) begin
         flip_mask[i] = correctable && (syn_q == ADDR_WIDTH'(i));
      end
      // Uncorrectable words pass through unmodified (mask is zero).
      fixed_code = code_q ^ flip_mask;
   end

   hamming_unpack #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_unpack (
      .code_in  (fixed_code),
      .data_out (unpacked)
   );

   always_comb begin
      data_d      = data_q;
      status_d    = status_q;
      out_valid_d = out_valid_q;
      if (en2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d = unpacked;
            if (!par_q && (syn_q == '0)) status_d = HAM_OK;
            else if (correctable)        status_d = HAM_CORRECTED;
            else                         status_d = HAM_UNCORRECTABLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code_q      <= '0;
         syn_q       <= '0;
         par_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         data_q      <= '0;
         status_q    <= HAM_OK;
         out_valid_q <= 1'b0;
      end else begin
         code_q      <= code_d;
         syn_q       <= syn_d;
         par_q       <= par_d;
         s1_valid_q  <= s1_valid_d;
         data_q      <= data_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign data_out   = data_q;
   assign status_out = status_q;
   assign out_valid  = out_valid_q;

   // ---------------- Error counters ----------------
`ifdef HAMMING_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
   logic [CNT_WIDTH-1:0] uncorr_cnt_q, uncorr_cnt_d;
   logic                 out_fire;

   always_comb begin
      out_fire     = out_valid_q && out_ready;
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_fire) begin
         if ((status_q == HAM_CORRECTED) && (corr_cnt_q != '1))
            corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
         if ((status_q == HAM_UNCORRECTABLE) && (uncorr_cnt_q != '1))
            uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign corr_cnt       = '0;
   assign uncorr_cnt     = '0;
`endif

endmodule
